javk_prefetch: RTL and testbench
================================

Name: javk_prefetch

Overview:
- Instruction prefetch unit between external 8-bit memory and the JAVK core's instruction register / control decoder.
- Fetches opcode bytes sequentially from a 16-bit fetch pointer over a req/ack memory handshake into a small FIFO.
- Presents the head byte and its address to the core; the core consumes with a take strobe.
- A redirect (jump/branch/reset vector) flushes the FIFO and restarts fetch at a new address.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 16'h0000, fetch address loaded on reset

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
mem_addr  output  16  fetch address; stable while mem_req high
mem_req  output  1  read request to memory
mem_ack  input  1  memory has valid mem_rdata this cycle
mem_rdata  input  8  byte read from memory
instr  output  8  head-of-FIFO opcode byte
instr_pc  output  16  address instr was fetched from
instr_valid  output  1  FIFO non-empty
instr_take  input  1  core consumes head byte this cycle
redirect  input  1  flush and restart fetch
redirect_pc  input  16  new fetch address when redirect high

Behaviour:
- Reset (rst low, async):
  - fetch_pc = RESET_PC; FIFO empty; state IDLE.
  - mem_req = 0, mem_addr = RESET_PC, instr_valid = 0, instr = 0, instr_pc = RESET_PC.
- Memory handshake:
  - At most one outstanding request.
  - mem_req and mem_addr are held constant until a rising edge samples mem_ack = 1; mem_rdata is captured on that edge.
  - mem_ack while mem_req = 0 is ignored.
  - Zero-wait memory (ack in the same cycle as req) yields one byte per cycle.
- FSM:
  - IDLE: if count < DEPTH, go to REQ with mem_req = 1 and mem_addr = fetch_pc.
  - REQ, on ack: push {mem_rdata, mem_addr}; fetch_pc += 1.
    - If count after the push/pop is < DEPTH, stay in REQ with mem_addr = new fetch_pc (back-to-back).
    - Otherwise go to IDLE with mem_req = 0.
  - REQ, on redirect without ack: go to DROP. mem_req stays high with the old address.
  - DROP, on ack: discard the byte; go to REQ at fetch_pc (already the redirect target).
- Capacity: issue only while count < DEPTH (count includes the byte arriving this edge, minus one if taken). The FIFO never overflows; a push to a full FIFO is a design error and must be asserted in simulation.
- Latency: ack edge to instr_valid = 1 is one cycle (registered FIFO). instr and instr_pc are registered and valid whenever instr_valid = 1.
- instr_take:
  - Pops on the rising edge when instr_valid = 1.
  - Take while empty is ignored.
  - Simultaneous push and pop keeps count unchanged.
- redirect (highest priority, any state):
  - FIFO flushed on that edge; instr_valid = 0 the next cycle; fetch_pc = redirect_pc.
  - A simultaneous instr_take or push is discarded.
  - Redirect coincident with ack in REQ: the byte is discarded and the unit goes to REQ at redirect_pc (no DROP).
  - Redirect in DROP updates fetch_pc only.
- Wrap-around: fetch_pc 16'hFFFF increments to 16'h0000; FIFO pointers wrap modulo DEPTH.
- Reset mid-request: mem_req drops immediately (async). Memory must tolerate an abandoned request.

Test Plan:
- Reset with rst low, release, zero-wait memory returning mem_rdata = addr[7:0] -> mem_addr 0,1,2,3 on consecutive cycles; instr_valid one cycle after the first ack; instr = 8'h00, instr_pc = 0.
- No instr_take, zero-wait memory -> exactly DEPTH = 4 acks, then mem_req = 0; taking one byte -> mem_req reasserts at addr 4 the next cycle.
- Memory acks only every 3rd cycle -> mem_addr held stable for 3 cycles per request; no duplicate or skipped bytes over 16 takes.
- redirect_pc = 16'h1234 while a request is outstanding without ack -> the late ack's byte never appears; the next instr has instr_pc = 16'h1234; FIFO contents from before the redirect are gone.
- redirect_pc = 16'hFFFE, take continuously -> instr_pc sequence FFFE, FFFF, 0000, 0001.
- Redirect, instr_take and ack all on the same edge -> FIFO empty the next cycle, no pop side effects, fetch restarts at redirect_pc; async reset asserted mid-REQ -> mem_req = 0 before the next clock edge.

Source files
------------

// File: rtl/javk_prefetch_if.sv
// Bus bundle for the JAVK instruction prefetch unit: the memory fetch side and
// the core-facing instruction stream.
interface javk_prefetch_if;
  // Handshakes: a memory transfer completes on a rising edge where mem_req and
  // mem_ack are both 1; mem_req/mem_addr stay fixed until then. A byte is
  // consumed on a rising edge where instr_valid and instr_take are both 1.
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [7:0]  instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_take;
  logic        redirect;
  logic [15:0] redirect_pc;

  modport master (
    output mem_addr, mem_req, instr, instr_pc, instr_valid,
    input  mem_ack, mem_rdata, instr_take, redirect, redirect_pc
  );

  modport slave (
    input  mem_addr, mem_req, instr, instr_pc, instr_valid,
    output mem_ack, mem_rdata, instr_take, redirect, redirect_pc
  );
endinterface

// File: rtl/javk_prefetch.sv
// Instruction prefetch: sequential byte fetch over req/ack into a small FIFO,
// head byte presented to the core, redirect flushes and restarts fetch.
module javk_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  javk_prefetch_if.master   bus,
  output logic [1:0]        dbg_state
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

  state_t        state, state_d;
  logic [15:0]   fetch_pc, fetch_pc_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    data_mem [DEPTH];
  logic [15:0]   pc_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, cnt_after;
  logic          push, pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_d;
      fetch_pc <= fetch_pc_d;
      addr_q   <= addr_d;
    end
  end

  // cnt_after is the occupancy after this edge; every issue decision uses it
  // so a byte taken this cycle frees its slot immediately.
  always_comb begin
    push       = (state == REQ) && bus.mem_ack && !bus.redirect;
    pop        = bus.instr_take && (count != '0) && !bus.redirect;
    cnt_after  = count;
    if (push) cnt_after = cnt_after + CW'(1);
    if (pop)  cnt_after = cnt_after - CW'(1);
    state_d    = state;
    fetch_pc_d = fetch_pc;
    addr_d     = addr_q;
    case (state)
      IDLE: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          addr_d     = bus.redirect_pc;
          state_d    = REQ;
        end else if (cnt_after < FULL) begin
          addr_d  = fetch_pc;
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.redirect) begin
          fetch_pc_d = bus.redirect_pc;
          if (bus.mem_ack) begin
            addr_d = bus.redirect_pc;
          end else begin
            state_d = DROP;
          end
        end else if (bus.mem_ack) begin
          fetch_pc_d = fetch_pc + 16'd1;
          addr_d     = fetch_pc + 16'd1;
          if (cnt_after >= FULL) state_d = IDLE;
        end
      end
      DROP: begin
        // The old request is still on the bus; its byte is thrown away.
        if (bus.redirect) fetch_pc_d = bus.redirect_pc;
        if (bus.mem_ack) begin
          addr_d  = bus.redirect ? bus.redirect_pc : fetch_pc;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= RESET_PC;
      end
    end else if (bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= bus.mem_rdata;
        pc_mem[wr_ptr]   <= addr_q;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_after;
    end
  end

  assign bus.mem_req     = (state != IDLE);
  assign bus.mem_addr    = addr_q;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = data_mem[rd_ptr];
  assign bus.instr_pc    = pc_mem[rd_ptr];
  assign dbg_state       = state;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) push |-> (count < FULL));
endmodule

// File: tb/tb_javk_prefetch.sv
// Directed bench for javk_prefetch: memory model, core driver, scoreboard of
// expected {pc, byte} pairs popped by a monitor on every consumed instruction.
module tb_javk_prefetch;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  javk_prefetch_if bus();

  javk_prefetch #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] exp_q[$];
  logic [23:0] e;

  int          ack_every = 1;
  logic        mem_stall = 1'b0;
  int          wait_cnt  = 0;
  int          ack_cnt   = 0;
  logic        hold_vld  = 1'b0;
  logic [15:0] hold_addr = '0;

  function automatic logic [7:0] mdata(input logic [15:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic expect_pc(input logic [15:0] pc);
    exp_q.push_back({pc, mdata(pc)});
  endtask

  task automatic drain(input int max);
    for (int i = 0; i < max && exp_q.size() != 0; i++) step();
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Memory model: answers in the same cycle as the request once ack_every
  // cycles of the current request have elapsed.
  always @(negedge clk) begin
    if (bus.mem_req && !mem_stall) begin
      if (wait_cnt >= ack_every - 1) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mdata(bus.mem_addr);
        wait_cnt      = 0;
        ack_cnt++;
      end else begin
        bus.mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.mem_ack = 1'b0;
      if (!bus.mem_req) wait_cnt = 0;
    end
  end

  // Monitor: samples after every driver has settled for the coming edge.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      if (hold_vld && bus.mem_req) chk("addr_hold", bus.mem_addr, hold_addr);
      hold_vld  = bus.mem_req && !bus.mem_ack;
      hold_addr = bus.mem_addr;
      if (bus.instr_valid && bus.instr_take && !bus.redirect) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_take: got pc %h, required no byte", bus.instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", bus.instr_pc, e[23:8]);
          chk("instr", bus.instr, e[7:0]);
        end
      end
    end else begin
      hold_vld = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.instr_take  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 8'h00;
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_instr", bus.instr, 8'h00);
    chk("rst_instr_pc", bus.instr_pc, 16'h0000);
    chk("rst_state", dbg_state, 2'd0);

    // Zero-wait fill with no takes.
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) expect_pc(16'(i));
    step();
    chk("p1_req", bus.mem_req, 1);
    chk("p1_addr0", bus.mem_addr, 16'h0000);
    chk("p1_valid0", bus.instr_valid, 0);
    step();
    chk("p1_addr1", bus.mem_addr, 16'h0001);
    chk("p1_valid1", bus.instr_valid, 1);
    chk("p1_instr", bus.instr, 8'h00);
    chk("p1_instr_pc", bus.instr_pc, 16'h0000);
    step();
    chk("p1_addr2", bus.mem_addr, 16'h0002);
    step();
    chk("p1_addr3", bus.mem_addr, 16'h0003);
    step();
    chk("p1_full_req", bus.mem_req, 0);
    step();
    step();
    chk("p1_ack_count", ack_cnt, 4);
    chk("p1_idle_req", bus.mem_req, 0);
    chk("p1_idle_state", dbg_state, 2'd0);

    // One take frees a slot and fetch resumes at address 4.
    expect_pc(16'h0004);
    bus.instr_take = 1'b1;
    step();
    bus.instr_take = 1'b0;
    chk("p2_req", bus.mem_req, 1);
    chk("p2_addr", bus.mem_addr, 16'h0004);

    // Slow memory, continuous takes: bytes 1..16 in order.
    ack_every = 3;
    for (int i = 5; i <= 16; i++) expect_pc(16'(i));
    bus.instr_take = 1'b1;
    drain(200);
    bus.instr_take = 1'b0;

    // Redirect while a request hangs without ack.
    mem_stall = 1'b1;
    step();
    step();
    step();
    chk("p4_req_pending", bus.mem_req, 1);
    chk("p4_state_req", dbg_state, 2'd1);
    exp_q.delete();
    for (int i = 0; i < 4; i++) expect_pc(16'h1234 + 16'(i));
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h1234;
    step();
    bus.redirect = 1'b0;
    chk("p4_state_drop", dbg_state, 2'd2);
    chk("p4_drop_req", bus.mem_req, 1);
    chk("p4_flushed", bus.instr_valid, 0);
    mem_stall = 1'b0;
    ack_every = 1;
    step();
    step();
    chk("p4_restart_addr", bus.mem_addr, 16'h1234);
    chk("p4_restart_state", dbg_state, 2'd1);
    bus.instr_take = 1'b1;
    drain(50);
    bus.instr_take = 1'b0;

    // Address wrap through 16'hFFFF with continuous takes.
    exp_q.delete();
    expect_pc(16'hFFFE);
    expect_pc(16'hFFFF);
    expect_pc(16'h0000);
    expect_pc(16'h0001);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    bus.instr_take  = 1'b1;
    step();
    bus.redirect = 1'b0;
    drain(50);
    bus.instr_take = 1'b0;

    // Redirect, take and ack on the same edge.
    step();
    step();
    chk("p6_req", bus.mem_req, 1);
    chk("p6_valid_before", bus.instr_valid, 1);
    exp_q.delete();
    expect_pc(16'h0ABC);
    expect_pc(16'h0ABD);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0ABC;
    bus.instr_take  = 1'b1;
    step();
    bus.redirect   = 1'b0;
    bus.instr_take = 1'b0;
    chk("p6_flushed", bus.instr_valid, 0);
    chk("p6_req_after", bus.mem_req, 1);
    chk("p6_addr", bus.mem_addr, 16'h0ABC);
    chk("p6_state", dbg_state, 2'd1);
    step();
    chk("p6_valid_new", bus.instr_valid, 1);
    chk("p6_head_pc", bus.instr_pc, 16'h0ABC);
    chk("p6_head", bus.instr, 8'hB6);
    bus.instr_take = 1'b1;
    drain(50);
    bus.instr_take = 1'b0;
    mem_stall = 1'b1;

    // Asynchronous reset in the middle of a request.
    step();
    step();
    chk("p7_req_before", bus.mem_req, 1);
    rst = 1'b0;
    #1;
    chk("p7_req_async", bus.mem_req, 0);
    chk("p7_valid_async", bus.instr_valid, 0);
    chk("p7_addr_async", bus.mem_addr, 16'h0000);
    chk("p7_state_async", dbg_state, 2'd0);
    exp_q.delete();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
